// File: rtl/seq_pkg.sv
// Shared types and constants for the pattern generator / 11010 detector run controller.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] SEQ_DEFAULT = 16'b0111010011011010;
  localparam logic [4:0]  DET_TARGET  = 5'b11010;

endpackage

// File: rtl/tick_div.sv
// Clock-enable divider: o_tick is high for one cycle every DIV enabled cycles.
// Counter is held at zero whenever i_en is low, so every enable period starts fresh.
module tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_run_ctrl.sv
// Run controller: steps the pattern generator for PASSES rotations on a divided tick
// and counts detector hits; owns the generator reload/step enables.
module seq_run_ctrl
  import seq_pkg::*;
#(
  parameter int DIV    = 25_000_000,
  parameter int SEQ_W  = 16,
  parameter int PASSES = 4,
  parameter int CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         pat_we,
  input  logic [SEQ_W-1:0]             pat_in,
  input  logic                         det_hit,
  output logic                         gen_reload,
  output logic [SEQ_W-1:0]             gen_pat,
  output logic                         gen_step,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [$clog2(PASSES+1)-1:0]  pass_cnt
);

  localparam int BW = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
  localparam int PW = $clog2(PASSES + 1);
  localparam logic [BW-1:0]    BIT_LAST  = BW'(SEQ_W - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
  localparam logic [CNT_W-1:0] HIT_MAX   = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [SEQ_W-1:0] r_gen_pat;
  logic             r_gen_step;
  logic             r_step_q;
  logic [BW-1:0]    r_bit_cnt;
  logic [PW-1:0]    r_pass_cnt;
  logic [CNT_W-1:0] r_hit_cnt;
  logic             w_tick;
  logic             w_run;
  logic             w_idle_done;
  logic             w_start_ok;
  logic             w_last_step;

  assign w_run       = (r_state == RUN);
  assign w_idle_done = (r_state == IDLE) || (r_state == DONE);
  assign w_start_ok  = start && !abort && w_idle_done;
  assign w_last_step = r_gen_step && (r_bit_cnt == BIT_LAST) && (r_pass_cnt == PASS_LAST);

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run),
    .o_tick (w_tick)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next = ARM;
      ARM:     w_next = abort ? IDLE : RUN;
      RUN: begin
        if (abort)            w_next = IDLE;
        else if (w_last_step) w_next = DRAIN;
      end
      DRAIN:   w_next = abort ? IDLE : DONE;
      DONE: begin
        if (abort)           w_next = IDLE;
        else if (w_start_ok) w_next = ARM;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gen_pat  <= SEQ_W'(SEQ_DEFAULT);
      r_gen_step <= 1'b0;
      r_step_q   <= 1'b0;
      r_bit_cnt  <= '0;
      r_pass_cnt <= '0;
      r_hit_cnt  <= '0;
    end else begin
      r_state    <= w_next;
      // An abort landing on a tick must not leak a step into IDLE.
      r_gen_step <= w_tick && !abort;
      r_step_q   <= r_gen_step;

      if (pat_we && w_idle_done) begin
        r_gen_pat <= pat_in;
      end

      if (w_start_ok) begin
        r_bit_cnt  <= '0;
        r_pass_cnt <= '0;
        r_hit_cnt  <= '0;
      end else begin
        if (w_run && r_gen_step) begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt  <= '0;
            r_pass_cnt <= r_pass_cnt + 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        if ((w_run || r_state == DRAIN) && r_step_q && det_hit && r_hit_cnt != HIT_MAX) begin
          r_hit_cnt <= r_hit_cnt + 1'b1;
        end
      end
    end
  end

  assign gen_reload = (r_state == ARM);
  assign gen_pat    = r_gen_pat;
  assign gen_step   = r_gen_step;
  assign busy       = (r_state == ARM) || (r_state == RUN) || (r_state == DRAIN);
  assign done       = (r_state == DONE);
  assign hit_cnt    = r_hit_cnt;
  assign pass_cnt   = r_pass_cnt;

endmodule
